// File: rtl/operand_issue_stage.sv
// operand_issue_stage
//   Decode-to-execute register stage placed directly after the 32-entry
//   register file. It captures both read operands with their decoded control,
//   resolves operands against the MEM and WB results, and bypasses the
//   register-file write happening in the same cycle. While execute is stalled,
//   it keeps the held operands fresh by snooping writebacks. It also detects
//   load-use hazards, stalls decode, inserts a bubble and counts stall cycles.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   id_*               decode-side instruction: valid, source/dest indices,
//                      register-file read data, immediate, control
//   flush              kills decode and execute contents (taken branch/jump)
//   ex_ready           execute accepts the held instruction this cycle
//   mem_*              MEM-stage writeback candidate (ALU results only)
//   wb_*               WB register-file write happening this edge
//   id_stall           combinational: decode must hold its instruction
//   ex_*               registered instruction presented to execute
//   stall_count        saturating count of cycles with id_stall asserted
module operand_issue_stage #(
    parameter int unsigned N     = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic [N-1:0]     id_rs1_data,
    input  logic [N-1:0]     id_rs2_data,
    input  logic [AW-1:0]    id_rd,
    input  logic [N-1:0]     id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,

    input  logic             flush,
    input  logic             ex_ready,

    input  logic             mem_reg_write,
    input  logic [AW-1:0]    mem_rd,
    input  logic [N-1:0]     mem_data,

    input  logic             wb_reg_write,
    input  logic [AW-1:0]    wb_rd,
    input  logic [N-1:0]     wb_data,

    output logic             id_stall,
    output logic             ex_valid,
    output logic [N-1:0]     ex_rs1_val,
    output logic [N-1:0]     ex_rs2_val,
    output logic [AW-1:0]    ex_rs1,
    output logic [AW-1:0]    ex_rs2,
    output logic [AW-1:0]    ex_rd,
    output logic [N-1:0]     ex_imm,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [AW-1:0]    ZeroReg = '0;
    localparam logic [N-1:0]     ZeroVal = '0;

    logic             loadUse;
    logic             holdEx;

    logic             exValidNxt;
    logic [N-1:0]     exRs1ValNxt;
    logic [N-1:0]     exRs2ValNxt;
    logic [AW-1:0]    exRs1Nxt;
    logic [AW-1:0]    exRs2Nxt;
    logic [AW-1:0]    exRdNxt;
    logic [N-1:0]     exImmNxt;
    logic             exRegWriteNxt;
    logic             exMemReadNxt;
    logic [CNT_W-1:0] stallCountNxt;

    // A producer matches a source only if it writes, targets that index, and
    // the index is not the hard-wired zero register.
    function automatic logic regMatch(
        input logic          we,
        input logic [AW-1:0] src,
        input logic [AW-1:0] dst
    );
        return we && (src == dst) && (dst != ZeroReg);
    endfunction

    // Operand resolution at capture: the youngest producer (MEM) wins over
    // WB, and WB wins over the register file, which has not seen this
    // cycle's write yet.
    function automatic logic [N-1:0] captureOperand(
        input logic [AW-1:0] src,
        input logic [N-1:0]  rfData,
        input logic          memWe,
        input logic [AW-1:0] memRd,
        input logic [N-1:0]  memData,
        input logic          wbWe,
        input logic [AW-1:0] wbRd,
        input logic [N-1:0]  wbData
    );
        logic [N-1:0] result;
        result = rfData;
        if (src == ZeroReg) begin
            result = ZeroVal;
        end else if (regMatch(memWe, src, memRd)) begin
            result = memData;
        end else if (regMatch(wbWe, src, wbRd)) begin
            result = wbData;
        end
        return result;
    endfunction

    // Refresh of a held operand while execute is stalled: producers that
    // retire during the stall would otherwise leave a stale value behind.
    function automatic logic [N-1:0] snoopOperand(
        input logic [AW-1:0] src,
        input logic [N-1:0]  held,
        input logic          memWe,
        input logic [AW-1:0] memRd,
        input logic [N-1:0]  memData,
        input logic          wbWe,
        input logic [AW-1:0] wbRd,
        input logic [N-1:0]  wbData
    );
        logic [N-1:0] result;
        result = held;
        if (regMatch(memWe, src, memRd)) begin
            result = memData;
        end else if (regMatch(wbWe, src, wbRd)) begin
            result = wbData;
        end
        return result;
    endfunction

    // Hazard detection and the decode stall
    assign loadUse = id_valid && ex_valid && ex_mem_read && (ex_rd != ZeroReg) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign holdEx  = ex_valid && !ex_ready;
    assign id_stall = !flush && id_valid && (loadUse || holdEx);

    // Next-state selection in edge priority: flush, hold, bubble, capture
    always_comb begin
        exValidNxt    = ex_valid;
        exRs1ValNxt   = ex_rs1_val;
        exRs2ValNxt   = ex_rs2_val;
        exRs1Nxt      = ex_rs1;
        exRs2Nxt      = ex_rs2;
        exRdNxt       = ex_rd;
        exImmNxt      = ex_imm;
        exRegWriteNxt = ex_reg_write;
        exMemReadNxt  = ex_mem_read;

        if (flush) begin
            exValidNxt    = 1'b0;
            exRegWriteNxt = 1'b0;
            exMemReadNxt  = 1'b0;
        end else if (holdEx) begin
            exRs1ValNxt = snoopOperand(ex_rs1, ex_rs1_val, mem_reg_write, mem_rd,
                                       mem_data, wb_reg_write, wb_rd, wb_data);
            exRs2ValNxt = snoopOperand(ex_rs2, ex_rs2_val, mem_reg_write, mem_rd,
                                       mem_data, wb_reg_write, wb_rd, wb_data);
        end else if (loadUse) begin
            exValidNxt    = 1'b0;
            exRegWriteNxt = 1'b0;
            exMemReadNxt  = 1'b0;
        end else begin
            exValidNxt    = id_valid;
            exRs1ValNxt   = captureOperand(id_rs1, id_rs1_data, mem_reg_write, mem_rd,
                                           mem_data, wb_reg_write, wb_rd, wb_data);
            exRs2ValNxt   = captureOperand(id_rs2, id_rs2_data, mem_reg_write, mem_rd,
                                           mem_data, wb_reg_write, wb_rd, wb_data);
            exRs1Nxt      = id_rs1;
            exRs2Nxt      = id_rs2;
            exRdNxt       = id_rd;
            exImmNxt      = id_imm;
            exRegWriteNxt = id_valid && id_reg_write;
            exMemReadNxt  = id_valid && id_mem_read;
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stallCountNxt = stall_count;
        if (id_stall && (stall_count != CntMax)) begin
            stallCountNxt = stall_count + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_imm       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            stall_count  <= '0;
        end else begin
            ex_valid     <= exValidNxt;
            ex_rs1_val   <= exRs1ValNxt;
            ex_rs2_val   <= exRs2ValNxt;
            ex_rs1       <= exRs1Nxt;
            ex_rs2       <= exRs2Nxt;
            ex_rd        <= exRdNxt;
            ex_imm       <= exImmNxt;
            ex_reg_write <= exRegWriteNxt;
            ex_mem_read  <= exMemReadNxt;
            stall_count  <= stallCountNxt;
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Bench for operand_issue_stage: directed vectors push hand-computed
// expected instructions into a queue; a monitor pops and compares each
// instruction execute accepts. A second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_operand_issue_stage;

    localparam int unsigned N     = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [N-1:0]  rs1Val;
        logic [N-1:0]  rs2Val;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic [N-1:0]  imm;
        logic          regWrite;
        logic          memRead;
    } expT;

    logic clk = 1'b0;
    logic reset;
    logic id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [N-1:0]  id_rs1_data, id_rs2_data, id_imm;
    logic id_reg_write, id_mem_read, flush, ex_ready;
    logic mem_reg_write, wb_reg_write;
    logic [AW-1:0] mem_rd, wb_rd;
    logic [N-1:0]  mem_data, wb_data;

    logic id_stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [N-1:0]  ex_rs1_val, ex_rs2_val, ex_imm;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [CNT_W-1:0] stall_count;

    logic smStall, smValid, smRegWrite, smMemRead;
    logic [N-1:0]  smRs1Val, smRs2Val, smImm;
    logic [AW-1:0] smRs1, smRs2, smRd;
    logic [1:0]    smCount;

    expT expQ[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_issue_stage #(.N(N), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd(id_rd), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .ex_ready(ex_ready),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .stall_count(stall_count)
    );

    operand_issue_stage #(.N(N), .AW(AW), .CNT_W(2)) dutSmall (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd(id_rd), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .ex_ready(ex_ready),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(smStall), .ex_valid(smValid),
        .ex_rs1_val(smRs1Val), .ex_rs2_val(smRs2Val),
        .ex_rs1(smRs1), .ex_rs2(smRs2), .ex_rd(smRd), .ex_imm(smImm),
        .ex_reg_write(smRegWrite), .ex_mem_read(smMemRead),
        .stall_count(smCount)
    );

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [N-1:0] d1, input logic [N-1:0] d2,
                         input logic [AW-1:0] rd, input logic [N-1:0] imm,
                         input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
        id_rd = rd; id_imm = imm; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic setFwd(input logic mw, input logic [AW-1:0] mrd, input logic [N-1:0] md,
                          input logic ww, input logic [AW-1:0] wrd, input logic [N-1:0] wd);
        mem_reg_write = mw; mem_rd = mrd; mem_data = md;
        wb_reg_write = ww; wb_rd = wrd; wb_data = wd;
    endtask

    task automatic pushExp(input logic [N-1:0] v1, input logic [N-1:0] v2,
                           input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                           input logic [AW-1:0] rd, input logic [N-1:0] imm,
                           input logic rw, input logic mr);
        expQ.push_back({v1, v2, r1, r2, rd, imm, rw, mr});
    endtask

    // Compares every instruction execute accepts against the queue head
    task automatic monitor();
        expT act;
        expT req;
        forever begin
            @(negedge clk);
            if (reset && ex_valid && ex_ready) begin
                act = {ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2, ex_rd, ex_imm,
                       ex_reg_write, ex_mem_read};
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL exOut unexpected instruction rd=%0d rs1Val=0x%0h rs2Val=0x%0h",
                             ex_rd, ex_rs1_val, ex_rs2_val);
                end else begin
                    req = expQ.pop_front();
                    if (act !== req) begin
                        errors++;
                        $display("FAIL exOut actual rs1Val=0x%0h rs2Val=0x%0h rs1=%0d rs2=%0d rd=%0d imm=0x%0h rw=%0b mr=%0b required rs1Val=0x%0h rs2Val=0x%0h rs1=%0d rs2=%0d rd=%0d imm=0x%0h rw=%0b mr=%0b",
                                 act.rs1Val, act.rs2Val, act.rs1, act.rs2, act.rd, act.imm, act.regWrite, act.memRead,
                                 req.rs1Val, req.rs2Val, req.rs1, req.rs2, req.rd, req.imm, req.regWrite, req.memRead);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        setId(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 5'd3, 32'h0, 1'b1, 1'b0);
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        fork
            monitor();
        join_none
        #2 reset = 1'b0;
        tick();
        tick();
        chk("resetExValid", 32'(ex_valid), 32'h0);
        chk("resetIdStall", 32'(id_stall), 32'h0);
        chk("resetCount", 32'(stall_count), 32'h0);
        chk("resetRs1Val", ex_rs1_val, 32'h0);
        reset = 1'b1;

        // Same-cycle WB bypass onto rs1; rs2 is x0
        setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h1234);
        setId(1'b1, 5'd10, 5'd0, 32'h0, 32'h999, 5'd3, 32'h10, 1'b1, 1'b0);
        pushExp(32'h1234, 32'h0, 5'd10, 5'd0, 5'd3, 32'h10, 1'b1, 1'b0);
        tick();
        // MEM beats WB on the same register
        setFwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        setId(1'b1, 5'd1, 5'd5, 32'h11, 32'h5555, 5'd4, 32'h20, 1'b1, 1'b0);
        pushExp(32'h11, 32'hAA, 5'd1, 5'd5, 5'd4, 32'h20, 1'b1, 1'b0);
        tick();
        // Same producers targeting x0: operand stays zero
        setFwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        setId(1'b1, 5'd1, 5'd0, 32'h11, 32'h77, 5'd4, 32'h21, 1'b1, 1'b0);
        pushExp(32'h11, 32'h0, 5'd1, 5'd0, 5'd4, 32'h21, 1'b1, 1'b0);
        tick();
        // MEM feeds rs1, WB feeds rs2
        setFwd(1'b1, 5'd6, 32'hC6, 1'b1, 5'd9, 32'hD9);
        setId(1'b1, 5'd6, 5'd9, 32'h66, 32'h99, 5'd5, 32'h22, 1'b0, 1'b0);
        pushExp(32'hC6, 32'hD9, 5'd6, 5'd9, 5'd5, 32'h22, 1'b0, 1'b0);
        tick();
        // Non-writing producers are ignored
        setFwd(1'b0, 5'd6, 32'hC6, 1'b0, 5'd9, 32'hD9);
        setId(1'b1, 5'd6, 5'd9, 32'h66, 32'h99, 5'd5, 32'h23, 1'b1, 1'b0);
        pushExp(32'h66, 32'h99, 5'd6, 5'd9, 5'd5, 32'h23, 1'b1, 1'b0);
        tick();

        // Load-use: lw x7 then add using x7
        setId(1'b1, 5'd2, 5'd0, 32'h100, 32'h0, 5'd7, 32'h4, 1'b1, 1'b1);
        pushExp(32'h100, 32'h0, 5'd2, 5'd0, 5'd7, 32'h4, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd7, 5'd8, 32'h0, 32'h80, 5'd9, 32'h30, 1'b1, 1'b0);
        @(negedge clk);
        chk("loadUseStall", 32'(id_stall), 32'h1);
        tick();
        setFwd(1'b0, 5'd7, 32'h104, 1'b1, 5'd7, 32'hDEAD);
        pushExp(32'hDEAD, 32'h80, 5'd7, 5'd8, 5'd9, 32'h30, 1'b1, 1'b0);
        @(negedge clk);
        chk("bubbleExValid", 32'(ex_valid), 32'h0);
        chk("bubbleIdStall", 32'(id_stall), 32'h0);
        chk("countAfterLoadUse", 32'(stall_count), 32'h1);
        chk("smallCountAfterLoadUse", 32'(smCount), 32'h1);
        tick();

        // Held operands refreshed during a 3-cycle execute stall
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        setId(1'b1, 5'd12, 5'd13, 32'h1, 32'h2, 5'd14, 32'h40, 1'b1, 1'b0);
        pushExp(32'h55, 32'h66, 5'd12, 5'd13, 5'd14, 32'h40, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        setId(1'b1, 5'd1, 5'd2, 32'h111, 32'h222, 5'd15, 32'h50, 1'b1, 1'b0);
        setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h55);
        @(negedge clk);
        chk("holdStall", 32'(id_stall), 32'h1);
        tick();
        setFwd(1'b1, 5'd13, 32'h66, 1'b1, 5'd13, 32'h77);
        tick();
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("heldRs1Val", ex_rs1_val, 32'h55);
        tick();
        ex_ready = 1'b1;
        pushExp(32'h111, 32'h222, 5'd1, 5'd2, 5'd15, 32'h50, 1'b1, 1'b0);
        @(negedge clk);
        chk("releaseIdStall", 32'(id_stall), 32'h0);
        chk("countAfterHold", 32'(stall_count), 32'h4);
        chk("smallCountSaturated", 32'(smCount), 32'h3);
        tick();

        // Flush during a load-use hazard
        setId(1'b1, 5'd3, 5'd0, 32'h300, 32'h0, 5'd7, 32'h8, 1'b1, 1'b1);
        pushExp(32'h300, 32'h0, 5'd3, 5'd0, 5'd7, 32'h8, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd7, 5'd0, 32'h0, 32'h0, 5'd10, 32'h0, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flushIdStall", 32'(id_stall), 32'h0);
        tick();
        flush = 1'b0;
        setId(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("flushExValid", 32'(ex_valid), 32'h0);
        chk("flushRegWrite", 32'(ex_reg_write), 32'h0);
        chk("flushMemRead", 32'(ex_mem_read), 32'h0);
        chk("countAfterFlush", 32'(stall_count), 32'h4);
        tick();

        // Asynchronous reset in the middle of a stall
        setId(1'b1, 5'd4, 5'd0, 32'h400, 32'h0, 5'd11, 32'h0, 1'b1, 1'b0);
        pushExp(32'h400, 32'h0, 5'd4, 5'd0, 5'd11, 32'h0, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        setId(1'b1, 5'd5, 5'd0, 32'h500, 32'h0, 5'd12, 32'h0, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        chk("countBeforeReset", 32'(stall_count), 32'h5);
        chk("stallBeforeReset", 32'(id_stall), 32'h1);
        #1;
        reset = 1'b0;
        expQ.delete();
        #1;
        chk("midResetExValid", 32'(ex_valid), 32'h0);
        chk("midResetIdStall", 32'(id_stall), 32'h0);
        chk("midResetCount", 32'(stall_count), 32'h0);
        chk("midResetSmallCount", 32'(smCount), 32'h0);
        chk("midResetRs1Val", ex_rs1_val, 32'h0);
        chk("midResetRd", 32'(ex_rd), 32'h0);
        chk("midResetRegWrite", 32'(ex_reg_write), 32'h0);
        tick();
        reset = 1'b1;
        ex_ready = 1'b1;

        // Recovery after reset
        setId(1'b1, 5'd6, 5'd7, 32'h600, 32'h700, 5'd12, 32'h60, 1'b0, 1'b0);
        pushExp(32'h600, 32'h700, 5'd6, 5'd7, 5'd12, 32'h60, 1'b0, 1'b0);
        tick();
        setId(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("queueDrained", 32'(expQ.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
